// File: rtl/rca16_mp_seq_if.sv
// rca16_mp_seq_if
// Byte-wide register port shared by the lab wrappers.
//   DIN  [7:0] : write data byte
//   ADDR [7:0] : register byte address
//   RDWR       : 1 = write DIN to ADDR, 0 = read ADDR into DOUT
//   DOUT [7:0] : registered read data
//   BUSY       : high while limbs are being added
// The master modport belongs to whoever drives accesses, the slave modport
// to the sequencer.
interface rca16_mp_seq_if;
  logic [7:0] DIN;
  logic [7:0] ADDR;
  logic       RDWR;
  logic [7:0] DOUT;
  logic       BUSY;

  modport master (output DIN, output ADDR, output RDWR, input DOUT, input BUSY);
  modport slave  (input DIN, input ADDR, input RDWR, output DOUT, output BUSY);
endinterface

// File: rtl/rca16_mp_seq.sv
// rca16_mp_seq
// Multi-precision add sequencer around one 16-bit ripple-carry adder (rca16).
// Operands A and B (16*NWORDS bits) are loaded byte by byte, then START feeds
// the adder one limb per cycle, least-significant first, with the carry held
// in a register between limbs.
//   CLK       : clock, rising edge
//   RST       : synchronous active-high reset
//   bus       : rca16_mp_seq_if.slave (DIN, ADDR, RDWR, DOUT, BUSY)
// Register map: 0x00+k A byte k, 0x10+k B byte k, 0x20+k S byte k (read-only),
// 0x30 CTRL (write-only, bit0 START, bit1 CIN),
// 0x31 STATUS (read-only, {4'b0, OVF, COUT, DONE, BUSY}).
// Optional feature: define RCA16_MP_OVF_EN to build the signed-overflow flag;
// without it STATUS bit3 reads 0.

// 16-bit ripple-carry adder, one full adder per bit.
module rca16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] s,
  output logic        cout
);
  // Carry ripples from bit 0 upward through a local chain.
  always_comb begin : ripple
    logic [16:0] c;
    c    = '0;
    s    = '0;
    c[0] = cin;
    for (int i = 0; i < 16; i++) begin
      s[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    cout = c[16];
  end
endmodule

module rca16_mp_seq #(
  parameter int NWORDS = 4
) (
  input logic          CLK,
  input logic          RST,
  rca16_mp_seq_if.slave bus
);
  localparam int         W        = 16 * NWORDS;
  localparam int         NBYTES   = 2 * NWORDS;
  localparam logic [2:0] IDX_LAST = 3'(NWORDS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   a_q, a_d;
  logic [W-1:0]   b_q, b_d;
  logic [W-1:0]   s_q, s_d;
  logic [2:0]     idx_q, idx_d;
  logic           carry_q, carry_d;
  logic           cin_q, cin_d;
  logic           cout_q, cout_d;
  logic [7:0]     dout_q, dout_d;
  logic           ovf_bit;
  logic [7:0]     rd_data;
  logic [15:0]    limb_a, limb_b, limb_s;
  logic           limb_cout;

`ifdef RCA16_MP_OVF_EN
  logic ovf_q, ovf_d;
  assign ovf_bit = ovf_q;
`else
  assign ovf_bit = 1'b0;
`endif

  assign bus.DOUT = dout_q;
  assign bus.BUSY = (state_q == RUN);

  // Route limb idx of both operands to the shared adder.
  always_comb begin
    limb_a = '0;
    limb_b = '0;
    for (int k = 0; k < NWORDS; k++) begin
      if (idx_q == 3'(k)) begin
        limb_a = a_q[16*k +: 16];
        limb_b = b_q[16*k +: 16];
      end
    end
  end

  rca16 u_add (
    .a    (limb_a),
    .b    (limb_b),
    .cin  (carry_q),
    .s    (limb_s),
    .cout (limb_cout)
  );

  // Read mux; bytes beyond the operand width and unmapped addresses read 0.
  always_comb begin
    rd_data = '0;
    for (int k = 0; k < NBYTES; k++) begin
      if (bus.ADDR[3:0] == 4'(k)) begin
        case (bus.ADDR[7:4])
          4'h0:    rd_data = a_q[8*k +: 8];
          4'h1:    rd_data = b_q[8*k +: 8];
          4'h2:    rd_data = s_q[8*k +: 8];
          default: rd_data = '0;
        endcase
      end
    end
    if (bus.ADDR == 8'h31) begin
      rd_data = {4'b0000, ovf_bit, cout_q, (state_q == DONE), (state_q == RUN)};
    end
  end

  // Next-state logic: register writes and START are only honoured outside
  // RUN, so the adder sees stable operands for the whole sequence.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    s_d     = s_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    cin_d   = cin_q;
    cout_d  = cout_q;
    dout_d  = dout_q;
`ifdef RCA16_MP_OVF_EN
    ovf_d   = ovf_q;
`endif
    if (!bus.RDWR) begin
      dout_d = rd_data;
    end
    case (state_q)
      RUN: begin
        for (int k = 0; k < NWORDS; k++) begin
          if (idx_q == 3'(k)) begin
            s_d[16*k +: 16] = limb_s;
          end
        end
        carry_d = limb_cout;
        idx_d   = idx_q + 3'd1;
        if (idx_q == IDX_LAST) begin
          state_d = DONE;
          cout_d  = limb_cout;
`ifdef RCA16_MP_OVF_EN
          ovf_d   = (limb_a[15] == limb_b[15]) && (limb_s[15] != limb_a[15]);
`endif
        end
      end
      default: begin
        if (bus.RDWR) begin
          for (int k = 0; k < NBYTES; k++) begin
            if (bus.ADDR[3:0] == 4'(k)) begin
              if (bus.ADDR[7:4] == 4'h0) a_d[8*k +: 8] = bus.DIN;
              if (bus.ADDR[7:4] == 4'h1) b_d[8*k +: 8] = bus.DIN;
            end
          end
          if (bus.ADDR == 8'h30) begin
            cin_d = bus.DIN[1];
            if (bus.DIN[0]) begin
              carry_d = bus.DIN[1];
              idx_d   = '0;
              cout_d  = 1'b0;
`ifdef RCA16_MP_OVF_EN
              ovf_d   = 1'b0;
`endif
              state_d = RUN;
            end
          end
        end
      end
    endcase
  end

  // All state registers, with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      cin_q   <= 1'b0;
      cout_q  <= 1'b0;
      dout_q  <= '0;
`ifdef RCA16_MP_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      s_q     <= s_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      cin_q   <= cin_d;
      cout_q  <= cout_d;
      dout_q  <= dout_d;
`ifdef RCA16_MP_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end
endmodule
